mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of data and address buses.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_req / cpu_we  input  1 / 1  CPU load-store request and write select.
REQ-005 cpu_addr / cpu_wdata  input  DATA_WIDTH each  CPU byte address and store data.
REQ-006 cpu_rdata  output  DATA_WIDTH  registered CPU load data; cpu_ack  output  1  one-cycle completion pulse.
REQ-007 cpu_stall  output  1  SHALL equal cpu_req AND NOT cpu_ack, combinationally.
REQ-008 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack SHALL mirror the CPU port signals for the debug/loader requester.
REQ-009 mem_en, mem_we  output  1 / 1;  mem_addr, mem_wdata  output  DATA_WIDTH;  mem_rdata  input  DATA_WIDTH. These form a single-port synchronous data-memory interface with 1-cycle read latency.
REQ-010 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-011 FSM states SHALL be IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on any req, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-012 In IDLE with any req high, the arbiter SHALL select an owner and latch that owner's we, addr and wdata into mem_we, mem_addr and mem_wdata.
REQ-013 In ACCESS, mem_en SHALL be 1 for exactly that cycle; mem_en SHALL be 0 in every other state.
REQ-014 In RESP, the owner's ack SHALL pulse high for exactly one cycle, and for a read the owner's rdata SHALL capture mem_rdata on that edge.
REQ-015 Latency SHALL be fixed: req sampled in cycle N, memory access in N+1, ack in N+2, IDLE in N+3; peak throughput is one transaction per 3 cycles.
REQ-016 A requester SHALL hold req and its signals stable until the grant edge; after the grant, the arbiter SHALL complete the transaction from its latched copy even if req drops.
REQ-017 A req still high in the IDLE cycle after an ack SHALL be treated as a new transaction.
REQ-018 Each rdata register SHALL hold its last read value and SHALL be unchanged by writes or by the other requester's transactions.
REQ-019 The non-owner's ack SHALL stay 0 throughout a transaction; a losing request SHALL remain pending and be granted at the next IDLE.
REQ-020 The arbiter SHALL keep a last_owner register that is updated on every grant.

Reset
REQ-021 While rst is high: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ack=dbg_ack=0, cpu_rdata=dbg_rdata=0, last_owner=DBG, busy=0.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction with no ack; mem_en=0 immediately, so a write in ACCESS is not committed if rst rises before that edge.

Configuration
REQ-023 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester that is not last_owner.
REQ-024 Without ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to the CPU (fixed priority); last_owner is still maintained.
REQ-025 A lone requester SHALL be granted immediately in both configurations.

Structure
REQ-026 A shared package SHALL hold the state typedef (IDLE/ACCESS/RESP), the owner typedef (OWNER_CPU=0, OWNER_DBG=1) and the memory read-latency constant (1).
REQ-027 Winner selection SHALL be a combinational sub-module named arb_pick, with inputs cpu_req, dbg_req and last_owner, and output grant owner.

Verification
REQ-028 CPU write addr 0x10 data 0xDEADBEEF, then CPU read 0x10 -> mem_en pulses in cycles 1 and 4; cpu_ack in cycles 2 and 5; cpu_rdata=0xDEADBEEF after cycle 5.
REQ-029 cpu_req and dbg_req rise together, both held high -> with ARB_ROUND_ROBIN_EN, grants alternate CPU, DBG, CPU; without it, the CPU wins every IDLE and DBG starves while cpu_req is held high.
REQ-030 dbg read 0x20 (memory holds 0x12345678) while cpu_rdata=0xAAAA5555 -> dbg_rdata=0x12345678; cpu_rdata unchanged; cpu_ack stays 0.
REQ-031 cpu_req drops in ACCESS during a write of 0x55 to 0x40 -> the write commits; cpu_ack still pulses in RESP.
REQ-032 rst pulsed during ACCESS of a DBG write of 0x99 to 0x80 -> no ack; memory at 0x80 unchanged; after release, the first simultaneous request goes to the CPU.
REQ-033 cpu_stall checked every cycle = cpu_req AND NOT cpu_ack.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU/debug data-memory arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin on simultaneous requests.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_e;

    localparam int MEM_RD_LATENCY = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [DATA_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;
    logic                  cpu_stall;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [DATA_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dbg_ack;

    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between CPU and debug requesters.
// ARB_ROUND_ROBIN_EN: a tie goes to whoever was not last_owner; else CPU wins.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   dbg_req_i,
    input  owner_e last_owner_i,
    output owner_e grant_o
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = (last_owner_i == OWNER_DBG);
`endif

    // Lone requester wins outright; ties resolved by the build option.
    always_comb begin
        grant_o = OWNER_CPU;
        priority case (1'b1)
`ifdef ARB_ROUND_ROBIN_EN
            cpu_req_i && dbg_req_i:
                grant_o = (last_owner_i == OWNER_CPU) ? OWNER_DBG : OWNER_CPU;
`else
            cpu_req_i && dbg_req_i:
                grant_o = OWNER_CPU;
`endif
            dbg_req_i: grant_o = OWNER_DBG;
            default:   grant_o = OWNER_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto a single-port synchronous data memory.
// Build option: ARB_ROUND_ROBIN_EN (see arb_pick); default is CPU priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    state_e                state_q;
    owner_e                owner_q;
    owner_e                last_owner_q;
    owner_e                owner_d;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  cpu_ack_q;
    logic                  dbg_ack_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_q;

    arb_pick u_pick (
        .cpu_req_i    (bus.cpu_req),
        .dbg_req_i    (bus.dbg_req),
        .last_owner_i (last_owner_q),
        .grant_o      (owner_d)
    );

    // Fixed three-cycle transaction: grant/latch, memory access, ack/capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_CPU;
            last_owner_q <= OWNER_DBG;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req || bus.dbg_req) begin
                        state_q      <= ACCESS;
                        mem_en_q     <= 1'b1;
                        owner_q      <= owner_d;
                        last_owner_q <= owner_d;
                        if (owner_d == OWNER_CPU) begin
                            mem_we_q    <= bus.cpu_we;
                            mem_addr_q  <= bus.cpu_addr;
                            mem_wdata_q <= bus.cpu_wdata;
                        end else begin
                            mem_we_q    <= bus.dbg_we;
                            mem_addr_q  <= bus.dbg_addr;
                            mem_wdata_q <= bus.dbg_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state_q   <= RESP;
                    mem_en_q  <= 1'b0;
                    cpu_ack_q <= (owner_q == OWNER_CPU);
                    dbg_ack_q <= (owner_q == OWNER_DBG);
                end
                RESP: begin
                    state_q   <= IDLE;
                    cpu_ack_q <= 1'b0;
                    dbg_ack_q <= 1'b0;
                    if (!mem_we_q) begin
                        if (owner_q == OWNER_CPU) begin
                            cpu_rdata_q <= bus.mem_rdata;
                        end else begin
                            dbg_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_en_q  <= 1'b0;
                    cpu_ack_q <= 1'b0;
                    dbg_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level model predicts grants,
// memory operations, acks and load data; a negedge monitor compares.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(32)) bus();

    mem_arbiter #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct {
        int          cyc;
        bit          dbg;
        bit          rd;
        logic [31:0] data;
    } ack_t;

    op_t  op_q[$];
    ack_t ack_q[$];

    function automatic logic [31:0] init_val(input logic [7:0] i);
        return (i == 8'h20) ? 32'h12345678 : {24'hC0FFEE, i};
    endfunction

    // Environment: synchronous single-port memory, one-cycle read latency.
    logic [31:0] mem [256];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
            mem_init <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    // Reference model state.
    int          cyc = 0;
    int          m_free = 0;
    bit          m_last = 1'b1;
    logic [31:0] model_mem [256];
    bit          pw_v = 1'b0;
    int          pw_cyc = 0;
    logic [7:0]  pw_a;
    logic [31:0] pw_d;

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
        forever begin
            @(posedge clk);
            if (rst) begin
                m_free = 0;
                m_last = 1'b1;
                pw_v   = 1'b0;
            end else begin
                if (pw_v && pw_cyc == cyc) begin
                    model_mem[pw_a] = pw_d;
                    pw_v = 1'b0;
                end
                if (cyc >= m_free && (bus.cpu_req || bus.dbg_req)) begin
                    bit w;
                    logic we;
                    logic [31:0] a, d;
                    if (bus.cpu_req && bus.dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        w = ~m_last;
`else
                        w = 1'b0;
`endif
                    end else begin
                        w = bus.dbg_req;
                    end
                    we = w ? bus.dbg_we : bus.cpu_we;
                    a  = w ? bus.dbg_addr : bus.cpu_addr;
                    d  = w ? bus.dbg_wdata : bus.cpu_wdata;
                    op_q.push_back('{cyc + 1, we, a, d});
                    ack_q.push_back('{cyc + 2, w, !we,
                                      we ? 32'h0 : model_mem[a[7:0]]});
                    if (we) begin
                        pw_v = 1'b1; pw_cyc = cyc + 1;
                        pw_a = a[7:0]; pw_d = d;
                    end
                    m_free = cyc + 3;
                    m_last = w;
                end
            end
            cyc = cyc + 1;
        end
    end

    // Monitor / scoreboard.
    logic [31:0] exp_cpu_rd = 32'h0;
    logic [31:0] exp_dbg_rd = 32'h0;
    bit          upd_v = 1'b0;
    int          upd_cyc = 0;
    bit          upd_dbg = 1'b0;
    logic [31:0] upd_d = 32'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_mem_en",   32'(bus.mem_en), 32'h0);
                chk("rst_mem_we",   32'(bus.mem_we), 32'h0);
                chk("rst_mem_addr", bus.mem_addr, 32'h0);
                chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
                chk("rst_cpu_ack",  32'(bus.cpu_ack), 32'h0);
                chk("rst_dbg_ack",  32'(bus.dbg_ack), 32'h0);
                chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
                chk("rst_dbg_rdata", bus.dbg_rdata, 32'h0);
                chk("rst_busy",     32'(bus.busy), 32'h0);
                op_q.delete();
                ack_q.delete();
                exp_cpu_rd = 32'h0;
                exp_dbg_rd = 32'h0;
                upd_v = 1'b0;
            end else begin
                bit ecpu, edbg, have;
                ack_t a;
                ecpu = 1'b0; edbg = 1'b0; have = 1'b0;
                a = '{0, 1'b0, 1'b0, 32'h0};
                while (op_q.size() > 0 && op_q[0].cyc < cyc) begin
                    chk("mem_access_missing", 32'(bus.mem_en), 32'h1);
                    void'(op_q.pop_front());
                end
                if (op_q.size() > 0 && op_q[0].cyc == cyc) begin
                    op_t o;
                    o = op_q.pop_front();
                    chk("mem_en", 32'(bus.mem_en), 32'h1);
                    chk("mem_we", 32'(bus.mem_we), 32'(o.we));
                    chk("mem_addr", bus.mem_addr, o.addr);
                    if (o.we) chk("mem_wdata", bus.mem_wdata, o.wdata);
                end else begin
                    chk("mem_en_idle", 32'(bus.mem_en), 32'h0);
                end
                while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                    chk("ack_missing", 32'(bus.cpu_ack | bus.dbg_ack), 32'h1);
                    void'(ack_q.pop_front());
                end
                if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
                    a = ack_q.pop_front();
                    have = 1'b1;
                    ecpu = !a.dbg;
                    edbg = a.dbg;
                end
                chk("cpu_ack", 32'(bus.cpu_ack), 32'(ecpu));
                chk("dbg_ack", 32'(bus.dbg_ack), 32'(edbg));
                if (upd_v && upd_cyc == cyc) begin
                    if (upd_dbg) exp_dbg_rd = upd_d;
                    else exp_cpu_rd = upd_d;
                    upd_v = 1'b0;
                end
                chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
                chk("dbg_rdata", bus.dbg_rdata, exp_dbg_rd);
                if (have && a.rd) begin
                    upd_v = 1'b1; upd_cyc = cyc + 1;
                    upd_dbg = a.dbg; upd_d = a.data;
                end
                chk("busy", 32'(bus.busy), 32'(cyc < m_free));
                chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req & ~ecpu));
            end
        end
    end

    // Requester drivers: inputs change 1 time unit after a rising edge.
    task automatic issue(input bit p, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
        if (p) begin
            bus.dbg_req = 1'b1; bus.dbg_we = we;
            bus.dbg_addr = a; bus.dbg_wdata = d;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we;
            bus.cpu_addr = a; bus.cpu_wdata = d;
        end
    endtask

    task automatic drop(input bit p);
        if (p) bus.dbg_req = 1'b0;
        else bus.cpu_req = 1'b0;
    endtask

    task automatic wait_ack(input bit p);
        int n;
        logic ak;
        n = 0;
        ak = 1'b0;
        while (!ak && n < 400) begin
            @(negedge clk);
            n++;
            ak = p ? bus.dbg_ack : bus.cpu_ack;
        end
        chk(p ? "dbg_ack_wait" : "cpu_ack_wait", 32'(ak), 32'h1);
    endtask

    task automatic txn(input bit p, input logic we, input logic [31:0] a,
                       input logic [31:0] d);
        issue(p, we, a, d);
        wait_ack(p);
        @(posedge clk); #1;
    endtask

    task automatic burst(input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            txn(p, 1'(i % 2), 32'(8'h60 + 8'(p * 8 + i)), 32'hB0 + 32'(i));
        end
        drop(p);
    endtask

    task automatic rand_run(input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            int g;
            txn(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                32'($urandom));
            g = int'($urandom_range(0, 3));
            if (g > 0) begin
                drop(p);
                repeat (g) @(posedge clk);
                #1;
            end
        end
        drop(p);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
        bus.dbg_addr = '0;  bus.dbg_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Write then read back at 0x10.
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 32'h10, 32'h0);
        drop(1'b0);
        @(negedge clk);
        chk("wr_rd_0x10", bus.cpu_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Debug read must leave CPU load data alone.
        txn(1'b0, 1'b1, 32'h30, 32'hAAAA5555);
        txn(1'b0, 1'b0, 32'h30, 32'h0);
        drop(1'b0);
        txn(1'b1, 1'b0, 32'h20, 32'h0);
        drop(1'b1);
        @(negedge clk);
        chk("dbg_rd_0x20", bus.dbg_rdata, 32'h12345678);
        chk("cpu_rd_kept", bus.cpu_rdata, 32'hAAAA5555);
        @(posedge clk); #1;

        // Request withdrawn after grant still completes.
        issue(1'b0, 1'b1, 32'h40, 32'h55);
        @(posedge clk); #1;
        drop(1'b0);
        wait_ack(1'b0);
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 32'h40, 32'h0);
        drop(1'b0);
        @(negedge clk);
        chk("drop_commit", bus.cpu_rdata, 32'h55);
        @(posedge clk); #1;

        // Both requesters held high.
        fork
            burst(1'b0, 3);
            burst(1'b1, 3);
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset during ACCESS of a debug write.
        issue(1'b1, 1'b1, 32'h80, 32'h99);
        @(posedge clk); #1;
        rst = 1'b1;
        drop(1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_no_commit", mem[8'h80], init_val(8'h80));
        issue(1'b0, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 1'b0, 32'h20, 32'h0);
        n = 0;
        while (!(bus.cpu_ack || bus.dbg_ack) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_first_cpu", 32'(bus.cpu_ack), 32'h1);
        @(posedge clk); #1;
        drop(1'b0);
        wait_ack(1'b1);
        @(posedge clk); #1;
        drop(1'b1);

        // Random traffic from both requesters.
        fork
            rand_run(1'b0, 40);
            rand_run(1'b1, 40);
        join
        repeat (10) @(posedge clk);
        chk("op_q_drained", 32'(op_q.size()), 32'h0);
        chk("ack_q_drained", 32'(ack_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
